// File: rtl/a2_bridge_responder_if.sv
// a2_bridge_responder_if
// Bridge register port between the FPGA bus master and the bridge responder.
//   sel_i   [2:0] register select
//   rd_n_i        read strobe, active low
//   wr_n_i        write strobe, active low
//   d_i     [7:0] write data from the FPGA
//   d_o     [7:0] read data back to the FPGA
// Modports: master (FPGA side) and slave (responder side).
interface a2_bridge_responder_if;
    logic [2:0] sel_i;
    logic       rd_n_i;
    logic       wr_n_i;
    logic [7:0] d_i;
    logic [7:0] d_o;

    modport master (
        output sel_i,
        output rd_n_i,
        output wr_n_i,
        output d_i,
        input  d_o
    );

    modport slave (
        input  sel_i,
        input  rd_n_i,
        input  wr_n_i,
        input  d_i,
        output d_o
    );
endinterface

// File: rtl/a2_bridge_responder.sv
// a2_bridge_responder
// Bridge-side responder for the multiplexed Apple II bridge port. Synchronizes
// the slot inputs, answers FPGA register reads, latches FPGA-written control and
// data-out values and drives them back onto the slot.
// Ports:
//   clk_logic           logic clock
//   reset               asynchronous active-high reset
//   bus                 bridge register port (sel/rd_n/wr_n/d), slave side
//   a2_addr_i   [15:0]  slot address
//   a2_data_i   [7:0]   slot data bus
//   a2_rw_n_i           slot R/W
//   a2_phi0_i           slot PHI0
//   a2_m2sel_n_i        slot M2SEL_n
//   a2_m2b0_i           slot M2B0
//   a2_control_n_i [5:0] {reset_n, nmi_n, dma_n, rdy_n, irq_n, inh_n}
//   dip_switches_n_i [3:0] board DIP switches
//   a2_data_o   [7:0]   slot data drive value
//   a2_data_oe_o        slot data output enable
//   a2_control_oe_o [7:0] open-drain pull-low enables
module a2_bridge_responder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  CONTROL_RESET = 8'hFF
) (
    input  logic                         clk_logic,
    input  logic                         reset,
    a2_bridge_responder_if.slave         bus,
    input  logic [15:0]                  a2_addr_i,
    input  logic [7:0]                   a2_data_i,
    input  logic                         a2_rw_n_i,
    input  logic                         a2_phi0_i,
    input  logic                         a2_m2sel_n_i,
    input  logic                         a2_m2b0_i,
    input  logic [5:0]                   a2_control_n_i,
    input  logic [3:0]                   dip_switches_n_i,
    output logic [7:0]                   a2_data_o,
    output logic                         a2_data_oe_o,
    output logic [7:0]                   a2_control_oe_o
);

    typedef enum logic [1:0] {StIdle, StArmed, StDrive} drive_state_e;

    // Packed slot inputs: {dip, control_n, m2b0, m2sel_n, phi0, rw_n, data, addr}.
    // Everything resets high except PHI0 (bit 25), which resets low.
    localparam logic [37:0] SYNC_RESET = {{12{1'b1}}, 1'b0, {25{1'b1}}};

    logic [37:0] sync_raw;
    logic [37:0] sync_q [SYNC_STAGES];
    logic [37:0] live;

    logic [15:0] addr_live;
    logic [7:0]  data_live;
    logic        rw_n_live;
    logic        phi0_live;
    logic        m2sel_n_live;
    logic        m2b0_live;
    logic [5:0]  control_n_live;
    logic [3:0]  dip_n_live;

    logic [7:0]   control_out_q;
    logic [7:0]   data_out_q;
    logic         drive_armed_q, drive_armed_d;
    drive_state_e state_q, state_d;
    logic         wr_n_prev_q;
    logic         phi0_prev_q;
    logic         data_oe_q;
    logic [7:0]   control_oe_q;

    logic [15:0] snap_addr_q;
    logic        snap_rw_n_q;
    logic        snap_m2sel_n_q;
    logic        snap_m2b0_q;
    logic [2:0]  snap_age_q;

    logic commit;
    logic commit_ctrl;
    logic commit_data;
    logic snap_take;
    logic phi0_fall;
    logic rw_bit;

    assign sync_raw = {dip_switches_n_i, a2_control_n_i, a2_m2b0_i, a2_m2sel_n_i,
                       a2_phi0_i, a2_rw_n_i, a2_data_i, a2_addr_i};

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RESET;
            end
        end else begin
            sync_q[0] <= sync_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign live           = sync_q[SYNC_STAGES-1];
    assign addr_live      = live[15:0];
    assign data_live      = live[23:16];
    assign rw_n_live      = live[24];
    assign phi0_live      = live[25];
    assign m2sel_n_live   = live[26];
    assign m2b0_live      = live[27];
    assign control_n_live = live[33:28];
    assign dip_n_live     = live[37:34];

    // One commit per low pulse: only the first edge that sees wr_n low counts.
    assign commit      = !bus.wr_n_i && wr_n_prev_q;
    assign commit_ctrl = commit && (bus.sel_i == 3'd0);
    assign commit_data = commit && (bus.sel_i == 3'd1);
    assign snap_take   = !bus.rd_n_i && (bus.sel_i == 3'd2);
    assign phi0_fall   = phi0_prev_q && !phi0_live;

    // A fresh snapshot keeps the addr/rw_n read sequence coherent; once it
    // ages out, idle polling sees the live line.
    assign rw_bit = (snap_age_q != 3'd7) ? snap_rw_n_q : rw_n_live;

    always_comb begin
        bus.d_o = 8'hFF;
        if (!bus.rd_n_i) begin
            case (bus.sel_i)
                3'd0:    bus.d_o = {1'b1, control_n_live, rw_bit};
                3'd1:    bus.d_o = data_live;
                3'd2:    bus.d_o = addr_live[7:0];
                3'd3:    bus.d_o = snap_addr_q[15:8];
                3'd4:    bus.d_o = {6'b111111, snap_m2sel_n_q, snap_m2b0_q};
                3'd5:    bus.d_o = {4'hF, dip_n_live};
                default: bus.d_o = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            snap_addr_q    <= 16'hFFFF;
            snap_rw_n_q    <= 1'b1;
            snap_m2sel_n_q <= 1'b1;
            snap_m2b0_q    <= 1'b1;
            snap_age_q     <= 3'd7;
        end else if (snap_take) begin
            snap_addr_q    <= addr_live;
            snap_rw_n_q    <= rw_n_live;
            snap_m2sel_n_q <= m2sel_n_live;
            snap_m2b0_q    <= m2b0_live;
            snap_age_q     <= 3'd0;
        end else if (snap_age_q != 3'd7) begin
            snap_age_q <= snap_age_q + 3'd1;
        end
    end

    // Drive FSM. drive_armed records a pending sel 1 commit; a commit during
    // DRIVE buys exactly one more read-cycle PHI0 phase.
    always_comb begin
        state_d       = state_q;
        drive_armed_d = drive_armed_q;
        if (commit_data) begin
            drive_armed_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (commit_data) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // A PHI0 phase of a write cycle leaves us armed.
                if (phi0_live && rw_n_live) begin
                    state_d       = StDrive;
                    drive_armed_d = commit_data;
                end
            end
            StDrive: begin
                if (phi0_fall) begin
                    state_d = drive_armed_d ? StArmed : StIdle;
                end
            end
            default: begin
                state_d       = StIdle;
                drive_armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            drive_armed_q <= 1'b0;
            data_oe_q     <= 1'b0;
            control_out_q <= CONTROL_RESET;
            data_out_q    <= 8'h00;
            control_oe_q  <= ~CONTROL_RESET;
            wr_n_prev_q   <= 1'b1;
            phi0_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            drive_armed_q <= drive_armed_d;
            // Registered from next state so the enable tracks the state flop.
            data_oe_q     <= (state_d == StDrive);
            if (commit_ctrl) begin
                control_out_q <= bus.d_i;
            end
            if (commit_data) begin
                data_out_q <= bus.d_i;
            end
            control_oe_q <= ~control_out_q;
            wr_n_prev_q  <= bus.wr_n_i;
            phi0_prev_q  <= phi0_live;
        end
    end

    assign a2_data_o       = data_out_q;
    assign a2_data_oe_o    = data_oe_q;
    assign a2_control_oe_o = control_oe_q;

endmodule

// File: tb/tb_a2_bridge_responder.sv
// tb_a2_bridge_responder
// Directed bench with a scoreboard: stimulus pushes expected values, a monitor
// on the falling clock edge pops and compares them against the DUT outputs.
module tb_a2_bridge_responder;

    localparam int KD_O  = 0;
    localparam int KOE   = 1;
    localparam int KDATA = 2;
    localparam int KCOE  = 3;

    logic        clk_logic;
    logic        reset;
    logic [15:0] a2_addr;
    logic [7:0]  a2_data;
    logic        a2_rw_n;
    logic        a2_phi0;
    logic        a2_m2sel_n;
    logic        a2_m2b0;
    logic [5:0]  a2_control_n;
    logic [3:0]  dip_n;
    logic [7:0]  a2_data_out;
    logic        a2_data_oe;
    logic [7:0]  a2_control_oe;

    a2_bridge_responder_if bus_if ();

    a2_bridge_responder #(
        .SYNC_STAGES   (2),
        .CONTROL_RESET (8'hFF)
    ) dut (
        .clk_logic        (clk_logic),
        .reset            (reset),
        .bus              (bus_if),
        .a2_addr_i        (a2_addr),
        .a2_data_i        (a2_data),
        .a2_rw_n_i        (a2_rw_n),
        .a2_phi0_i        (a2_phi0),
        .a2_m2sel_n_i     (a2_m2sel_n),
        .a2_m2b0_i        (a2_m2b0),
        .a2_control_n_i   (a2_control_n),
        .dip_switches_n_i (dip_n),
        .a2_data_o        (a2_data_out),
        .a2_data_oe_o     (a2_data_oe),
        .a2_control_oe_o  (a2_control_oe)
    );

    typedef struct {
        int         kind;
        logic [7:0] val;
        string      name;
    } chk_t;

    chk_t exp_q[$];
    logic chk_req;
    int   n_tests;
    int   n_failed;

    initial clk_logic = 1'b0;
    always #5 clk_logic = ~clk_logic;

    // Monitor: compares every queued expectation when stimulus requests a sample.
    always @(negedge clk_logic) begin
        chk_t       c;
        logic [7:0] act;
        if (chk_req) begin
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                case (c.kind)
                    KD_O:    act = bus_if.d_o;
                    KOE:     act = {7'b0, a2_data_oe};
                    KDATA:   act = a2_data_out;
                    default: act = a2_control_oe;
                endcase
                n_tests++;
                if (act !== c.val) begin
                    n_failed++;
                    $display("FAIL %s: got %02h, expected %02h", c.name, act, c.val);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_logic);
            #1;
        end
    endtask

    task automatic expect_val(input int kind, input logic [7:0] v, input string name);
        chk_t c;
        c.kind = kind;
        c.val  = v;
        c.name = name;
        exp_q.push_back(c);
    endtask

    task automatic sample();
        chk_req = 1'b1;
        @(negedge clk_logic);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [7:0] v, input string name);
        bus_if.sel_i  = sel;
        bus_if.rd_n_i = 1'b0;
        expect_val(KD_O, v, name);
        sample();
        tick();
        bus_if.rd_n_i = 1'b1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        bus_if.sel_i  = sel;
        bus_if.d_i    = d;
        bus_if.wr_n_i = 1'b0;
        tick();
        bus_if.wr_n_i = 1'b1;
    endtask

    task automatic set_phi0(input logic v, input int n);
        a2_phi0 = v;
        tick(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_failed = 0;
        chk_req  = 1'b0;
        reset    = 1'b1;
        bus_if.sel_i  = 3'd0;
        bus_if.rd_n_i = 1'b1;
        bus_if.wr_n_i = 1'b1;
        bus_if.d_i    = 8'h00;
        a2_addr      = 16'h0000;
        a2_data      = 8'h3C;
        a2_rw_n      = 1'b1;
        a2_phi0      = 1'b0;
        a2_m2sel_n   = 1'b1;
        a2_m2b0      = 1'b1;
        a2_control_n = 6'b101110;
        dip_n        = 4'hA;

        // Power-on reset state.
        tick(2);
        expect_val(KD_O, 8'hFF, "por_d_o");
        expect_val(KOE, 8'h00, "por_oe");
        expect_val(KDATA, 8'h00, "por_data_o");
        expect_val(KCOE, 8'h00, "por_ctrl_oe");
        sample();
        reset = 1'b0;
        tick(3);
        rd(3'd0, 8'hDD, "por_sel0");

        // Address coherence.
        a2_addr    = 16'hC0A5;
        a2_rw_n    = 1'b1;
        a2_m2sel_n = 1'b0;
        a2_m2b0    = 1'b1;
        tick(3);
        rd(3'd2, 8'hA5, "sel2_live_lo");
        a2_addr    = 16'h1234;
        a2_rw_n    = 1'b0;
        a2_m2sel_n = 1'b1;
        a2_m2b0    = 1'b0;
        tick(3);
        rd(3'd3, 8'hC0, "sel3_snap_hi");
        rd(3'd4, 8'hFD, "sel4_snap_m2");
        rd(3'd0, 8'hDD, "sel0_snap_rw");
        tick(10);
        rd(3'd0, 8'hDC, "sel0_live_rw");
        rd(3'd1, 8'h3C, "sel1_live_data");

        // Control write: single commit on a 3-cycle low pulse.
        bus_if.sel_i  = 3'd0;
        bus_if.d_i    = 8'hFB;
        bus_if.wr_n_i = 1'b0;
        tick();
        bus_if.d_i = 8'h00;
        expect_val(KCOE, 8'h00, "ctrl_oe_latency");
        sample();
        tick();
        expect_val(KCOE, 8'h04, "ctrl_oe_commit");
        sample();
        tick();
        bus_if.wr_n_i = 1'b1;
        tick(2);
        expect_val(KCOE, 8'h04, "ctrl_single_commit");
        sample();

        // Data drive on a read cycle.
        a2_rw_n = 1'b1;
        tick(3);
        wr(3'd1, 8'h5A);
        expect_val(KDATA, 8'h5A, "data_o_5a");
        expect_val(KOE, 8'h00, "oe_armed_idle");
        sample();
        tick();
        a2_phi0 = 1'b1;
        tick();
        expect_val(KOE, 8'h00, "oe_rise_c1");
        sample();
        tick();
        expect_val(KOE, 8'h00, "oe_rise_c2");
        sample();
        tick();
        expect_val(KOE, 8'h01, "oe_rise_c3");
        sample();
        tick(3);
        a2_phi0 = 1'b0;
        tick(2);
        expect_val(KOE, 8'h01, "oe_fall_c2");
        sample();
        tick();
        expect_val(KOE, 8'h00, "oe_fall_c3");
        sample();
        set_phi0(1'b1, 5);
        expect_val(KOE, 8'h00, "no_redrive");
        sample();
        set_phi0(1'b0, 4);

        // Armed during a write cycle: drive waits for the next read cycle.
        a2_rw_n = 1'b0;
        tick(3);
        wr(3'd1, 8'h33);
        set_phi0(1'b1, 5);
        expect_val(KOE, 8'h00, "write_cycle_no_drive");
        sample();
        set_phi0(1'b0, 4);
        expect_val(KOE, 8'h00, "write_cycle_still_armed");
        sample();
        a2_rw_n = 1'b1;
        tick(3);
        set_phi0(1'b1, 3);
        expect_val(KOE, 8'h01, "next_read_drive");
        expect_val(KDATA, 8'h33, "data_o_33");
        sample();

        // Commit during DRIVE: immediate data update and one more phase.
        wr(3'd1, 8'h77);
        expect_val(KDATA, 8'h77, "data_o_update");
        expect_val(KOE, 8'h01, "stay_drive");
        sample();
        set_phi0(1'b0, 3);
        expect_val(KOE, 8'h00, "rearm_fall");
        sample();
        set_phi0(1'b1, 3);
        expect_val(KOE, 8'h01, "rearm_drive");
        sample();
        set_phi0(1'b0, 3);
        set_phi0(1'b1, 5);
        expect_val(KOE, 8'h00, "rearm_once");
        sample();
        set_phi0(1'b0, 4);

        // Unmapped and idle.
        wr(3'd5, 8'h00);
        tick();
        expect_val(KCOE, 8'h04, "sel5_wr_ctrl");
        expect_val(KDATA, 8'h77, "sel5_wr_data");
        expect_val(KOE, 8'h00, "sel5_wr_oe");
        sample();
        rd(3'd5, 8'hFA, "sel5_dip");
        rd(3'd6, 8'hFF, "sel6_unmapped");
        rd(3'd7, 8'hFF, "sel7_unmapped");
        bus_if.sel_i = 3'd1;
        expect_val(KD_O, 8'hFF, "rd_n_high");
        sample();

        // Reset in the middle of a drive.
        wr(3'd1, 8'hA5);
        set_phi0(1'b1, 3);
        expect_val(KOE, 8'h01, "pre_reset_drive");
        sample();
        tick();
        bus_if.sel_i  = 3'd0;
        bus_if.rd_n_i = 1'b0;
        reset = 1'b1;
        expect_val(KOE, 8'h00, "reset_oe");
        expect_val(KD_O, 8'hFF, "reset_d_o");
        expect_val(KCOE, 8'h00, "reset_ctrl_oe");
        expect_val(KDATA, 8'h00, "reset_data_o");
        sample();
        bus_if.rd_n_i = 1'b1;
        tick(2);
        reset   = 1'b0;
        a2_phi0 = 1'b0;
        tick(4);
        rd(3'd0, 8'hDD, "post_reset_sel0");
        expect_val(KCOE, 8'h00, "post_reset_ctrl_oe");
        expect_val(KOE, 8'h00, "post_reset_oe");
        sample();

        tick(2);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
